life_run_ctrl: RTL and testbench

//  Sequencer directly upstream of the 8x8 life array. Loads a 64-bit seed into
//  the array's four 4x4 quadrants, then issues step pulses at a programmable

---
 rtl/life_run_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_life_run_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_run_ctrl.sv
// Run sequencer for the 8x8 life array: seed load, timed
// generation steps and post-step stable/extinct scan.
module life_run_ctrl #(
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         seed,
  input  logic                load,
  input  logic                run,
  input  logic                single,
  input  logic [PERIOD_W-1:0] period,
  input  logic                stop_on_stable,
  output logic [15:0]         vali,
  output logic [1:0]          vali_selector,
  output logic                write_enb,
  output logic [1:0]          valo_selector,
  output logic                step,
  input  logic [15:0]         valo,
  input  logic [15:0]         valo_prev,
  output logic                busy,
  output logic [GEN_W-1:0]    gen_count,
  output logic                stable,
  output logic                extinct,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_STEP,
    S_SCAN
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_idx;
  logic [63:0]         r_seed;
  logic [PERIOD_W-1:0] r_wcnt;
  logic [GEN_W-1:0]    r_gen;
  logic                r_stable;
  logic                r_extinct;
  logic                r_done;
  logic                r_from_single;
  logic                r_acc_eq;
  logic                r_acc_zero;

  logic                w_load_ok;
  logic [PERIOD_W-1:0] w_per_last;
  logic                w_wait_end;
  logic                w_first;
  logic                w_eq;
  logic                w_zero;
  logic                w_new_stab;
  logic                w_scan_end;
  logic                w_load_end;

  // load is ignored only while a load is already in progress
  assign w_load_ok  = load && (r_state != S_LOAD);
  // a zero period behaves like a one-cycle wait
  assign w_per_last = (period == '0) ? '0
                                     : period - PERIOD_W'(1);
  assign w_wait_end = (r_wcnt >= w_per_last);
  // quadrant 0 restarts the AND-accumulation
  assign w_first    = (r_idx == 2'd0);
  assign w_eq       = (w_first | r_acc_eq) & (valo == valo_prev);
  assign w_zero     = (w_first | r_acc_zero) & (valo == 16'h0000);
  // an empty board counts as stable too
  assign w_new_stab = w_eq | w_zero;
  assign w_scan_end = (r_state == S_SCAN) && (r_idx == 2'd3);
  assign w_load_end = (r_state == S_LOAD) && (r_idx == 2'd3);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state decode; load overrides everything else
  always_comb begin
    w_next = r_state;
    if (w_load_ok) begin
      w_next = S_LOAD;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (single)   w_next = S_STEP;
          else if (run) w_next = S_WAIT;
        end
        S_LOAD: begin
          if (r_idx == 2'd3) w_next = S_IDLE;
        end
        S_WAIT: begin
          if (!run)            w_next = S_IDLE;
          else if (w_wait_end) w_next = S_STEP;
        end
        S_STEP: w_next = S_SCAN;
        S_SCAN: begin
          if (r_idx == 2'd3) begin
            if (r_from_single || !run ||
                (stop_on_stable && w_new_stab))
              w_next = S_IDLE;
            else
              w_next = S_WAIT;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Moore outputs from registered state and quadrant index
  always_comb begin
    vali          = 16'h0000;
    vali_selector = 2'b00;
    write_enb     = 1'b0;
    valo_selector = 2'b00;
    step          = 1'b0;
    busy          = (r_state != S_IDLE);
    unique case (r_state)
      S_LOAD: begin
        write_enb     = 1'b1;
        vali_selector = r_idx;
        vali          = r_seed[{r_idx, 4'b0000} +: 16];
      end
      S_STEP:  step          = 1'b1;
      S_SCAN:  valo_selector = r_idx;
      default: ;
    endcase
  end

  // datapath: seed, counters, scan accumulators and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= 2'd0;
      r_seed        <= 64'h0;
      r_wcnt        <= '0;
      r_gen         <= '0;
      r_stable      <= 1'b0;
      r_extinct     <= 1'b0;
      r_done        <= 1'b0;
      r_from_single <= 1'b0;
      r_acc_eq      <= 1'b0;
      r_acc_zero    <= 1'b0;
    end else begin
      if (w_load_ok) r_seed <= seed;

      if ((w_next == r_state) &&
          ((r_state == S_LOAD) || (r_state == S_SCAN)))
        r_idx <= r_idx + 2'd1;
      else
        r_idx <= 2'd0;

      if (r_state == S_WAIT) r_wcnt <= r_wcnt + PERIOD_W'(1);
      else                   r_wcnt <= '0;

      if (r_state == S_IDLE) r_from_single <= single & ~load;

      if (r_state == S_SCAN) begin
        r_acc_eq   <= w_eq;
        r_acc_zero <= w_zero;
      end

      if (w_load_end)
        r_gen <= '0;
      else if (r_state == S_STEP)
        r_gen <= r_gen + GEN_W'(1);

      if (w_load_end) begin
        r_stable  <= 1'b0;
        r_extinct <= 1'b0;
      end else if (w_scan_end && !w_load_ok) begin
        r_stable  <= w_new_stab;
        r_extinct <= w_zero;
      end

      r_done <= w_scan_end && !w_load_ok;
    end
  end

  assign gen_count = r_gen;
  assign stable    = r_stable;
  assign extinct   = r_extinct;
  assign done      = r_done;

endmodule

// File: tb/tb_life_run_ctrl.sv
// Bench for life_run_ctrl: behavioural 8x8 life array plus
// queue scoreboard for write cycles and scan results.
module tb_life_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] seed;
  logic        load, run, single, stop_on_stable;
  logic [23:0] period;
  logic [15:0] vali, valo, valo_prev;
  logic [1:0]  vali_selector, valo_selector;
  logic        write_enb, step, busy, stable, extinct, done;
  logic [15:0] gen_count;

  life_run_ctrl #(.PERIOD_W(24), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .seed(seed), .load(load),
    .run(run), .single(single), .period(period),
    .stop_on_stable(stop_on_stable), .vali(vali),
    .vali_selector(vali_selector), .write_enb(write_enb),
    .valo_selector(valo_selector), .step(step), .valo(valo),
    .valo_prev(valo_prev), .busy(busy), .gen_count(gen_count),
    .stable(stable), .extinct(extinct), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] d;
  } wr_t;

  typedef struct packed {
    logic        st;
    logic        ex;
    logic [15:0] g;
  } sc_t;

  wr_t wq[$];
  sc_t sq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_steps = 0;
  int last_step = 0;
  bit have_last = 0;
  bit chk_space = 0;
  int exp_space = 0;
  bit m_single  = 0;
  logic [15:0] m_gen = '0;

  logic [63:0] a_cur  = '0;
  logic [63:0] a_prev = '0;
  logic [63:0] nb;
  sc_t         sc_new;

  // board bit = row*8+col; quadrant word bit i = col*4+row
  function automatic int qidx(input logic [1:0] q, input int i);
    return ((q[0] ? 4 : 0) + i % 4) * 8 + (q[1] ? 4 : 0) + i / 4;
  endfunction

  function automatic logic [15:0] get_quad(input logic [63:0] b,
                                           input logic [1:0] q);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[i] = b[qidx(q, i)];
    return w;
  endfunction

  function automatic logic [63:0] put_quad(input logic [63:0] b,
                                           input logic [1:0] q,
                                           input logic [15:0] w);
    logic [63:0] r;
    r = b;
    for (int i = 0; i < 16; i++) r[qidx(q, i)] = w[i];
    return r;
  endfunction

  // Conway rule, cells outside the 8x8 board are dead
  function automatic logic [63:0] life(input logic [63:0] b);
    logic [63:0] n;
    int k;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) &&
                r + dr >= 0 && r + dr < 8 &&
                c + dc >= 0 && c + dc < 8)
              k += int'(b[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = (k == 3) || (k == 2 && b[r * 8 + c]);
      end
    return n;
  endfunction

  function automatic void check(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  assign valo      = get_quad(a_cur, valo_selector);
  assign valo_prev = get_quad(a_prev, valo_selector);

  // array model; each step pushes the expected scan result
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (write_enb) a_cur <= put_quad(a_cur, vali_selector, vali);
    if (step) begin
      nb        = life(a_cur);
      m_gen     = m_gen + 16'd1;
      sc_new.ex = (nb == 64'h0);
      sc_new.st = (nb == a_cur) || (nb == 64'h0);
      sc_new.g  = m_gen;
      sq.push_back(sc_new);
      a_prev <= a_cur;
      a_cur  <= nb;
    end
  end

  // monitor: pops expectations whenever the DUT presents output
  always @(negedge clk) begin
    wr_t w;
    sc_t s;
    if (!reset) begin
      if (write_enb) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 64'(write_enb), 64'h0);
        end else begin
          w = wq.pop_front();
          check("write_sel", 64'(vali_selector), 64'(w.sel));
          check("write_data", 64'(vali), 64'(w.d));
        end
      end
      if (step) begin
        n_steps++;
        if (chk_space && have_last)
          check("step_spacing", 64'(cyc - last_step), 64'(exp_space));
        last_step = cyc;
        have_last = 1;
      end
      if (done) begin
        if (sq.size() == 0) begin
          check("unexpected_done", 64'(done), 64'h0);
        end else begin
          s = sq.pop_front();
          check("scan_stable", 64'(stable), 64'(s.st));
          check("scan_extinct", 64'(extinct), 64'(s.ex));
          check("scan_gen", 64'(gen_count), 64'(s.g));
          if (m_single || (stop_on_stable && (s.st || s.ex))) begin
            check("idle_after_done", 64'(busy), 64'h0);
            have_last = 0;
          end
        end
      end
    end
  end

  task automatic do_load(input logic [63:0] s);
    wr_t w;
    @(posedge clk); #1;
    seed = s;
    load = 1;
    run  = 0;
    m_single = 0;
    for (int q = 0; q < 4; q++) begin
      w.sel = 2'(q);
      w.d   = s[16 * q +: 16];
      wq.push_back(w);
    end
    sq.delete();
    m_gen = '0;
    @(posedge clk); #1;
    load = 0;
    seed = {$urandom, $urandom};
  endtask

  task automatic do_single();
    @(posedge clk); #1;
    single   = 1;
    m_single = 1;
    @(posedge clk); #1;
    single = 0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(nm, 64'(busy), 64'h0);
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    check(nm, 64'(ok), 64'h1);
  endtask

  task automatic wait_steps(input int tgt, input int budget,
                            input string nm);
    int i;
    i = 0;
    while (n_steps < tgt && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(nm, 64'(n_steps >= tgt), 64'h1);
  endtask

  initial begin
    int base;
    int p;
    logic [63:0] s;

    reset = 1; seed = '0; load = 0; run = 0; single = 0;
    period = '0; stop_on_stable = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_we", 64'(write_enb), 64'h0);
    check("rst_step", 64'(step), 64'h0);
    check("rst_gen", 64'(gen_count), 64'h0);
    check("rst_flags", 64'({stable, extinct, done}), 64'h0);
    check("rst_sel", 64'({vali_selector, valo_selector}), 64'h0);
    reset = 0;

    // single live cell
    do_load(64'h1);
    wait_idle(20, "t1_idle");
    check("t1_gen", 64'(gen_count), 64'h0);

    // single step of a lone cell -> dies
    base = n_steps;
    do_single();
    wait_idle(30, "t2_idle");
    check("t2_steps", 64'(n_steps - base), 64'h1);
    check("t2_ext", 64'(extinct), 64'h1);
    check("t2_stab", 64'(stable), 64'h1);
    check("t2_gen", 64'(gen_count), 64'h1);

    // block still life stops the run after one step
    do_load({16'h0001, 16'h0008, 16'h1000, 16'h8000});
    wait_idle(20, "t3_load_idle");
    base = n_steps;
    period = 24'd3; stop_on_stable = 1; run = 1;
    wait_done(40, "t3_done");
    run = 0;
    check("t3_busy", 64'(busy), 64'h0);
    repeat (10) @(negedge clk);
    check("t3_steps", 64'(n_steps - base), 64'h1);
    check("t3_stab", 64'(stable), 64'h1);
    check("t3_ext", 64'(extinct), 64'h0);

    // blinker free-run, spacing period+5, stray single ignored
    do_load(64'h00E0);
    wait_idle(20, "t4_load_idle");
    base = n_steps;
    period = 24'd3; stop_on_stable = 0;
    exp_space = 8; have_last = 0; chk_space = 1; run = 1;
    wait_steps(base + 2, 100, "t4_two_steps");
    single = 1;
    @(negedge clk);
    single = 0;
    wait_steps(base + 6, 100, "t4_six_steps");
    run = 0; chk_space = 0;
    wait_idle(20, "t4_idle");
    check("t4_stab", 64'(stable), 64'h0);

    // load during WAIT aborts the run and clears state
    do_load(64'h1);
    wait_idle(20, "t5_load_idle");
    period = 24'd20; stop_on_stable = 0; run = 1;
    wait_done(60, "t5_done");
    check("t5_ext_before", 64'(extinct), 64'h1);
    repeat (5) @(negedge clk);
    base = n_steps;
    do_load(64'h00E0);
    wait_idle(20, "t5_idle");
    repeat (30) @(negedge clk);
    check("t5_no_step", 64'(n_steps - base), 64'h0);
    check("t5_gen", 64'(gen_count), 64'h0);
    check("t5_flags", 64'({stable, extinct}), 64'h0);

    // reset on the second load cycle
    do_load(64'h1234_5678_9ABC_DEF0);
    @(posedge clk); #1;
    check("t6_we_pre", 64'(write_enb), 64'h1);
    check("t6_sel_pre", 64'(vali_selector), 64'h1);
    reset = 1;
    #1;
    check("t6_we", 64'(write_enb), 64'h0);
    check("t6_vali", 64'(vali), 64'h0);
    check("t6_sel", 64'(vali_selector), 64'h0);
    check("t6_busy", 64'(busy), 64'h0);
    wq.delete();
    sq.delete();
    m_gen = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    repeat (10) @(negedge clk);
    check("t6_busy_after", 64'(busy), 64'h0);

    // randomized seeds, singles and runs
    for (int it = 0; it < 10; it++) begin
      s = {$urandom, $urandom} & {$urandom, $urandom};
      do_load(s);
      wait_idle(20, "rnd_load_idle");
      if ($urandom_range(0, 2) == 0) begin
        do_single();
        wait_idle(30, "rnd_single_idle");
      end else begin
        p = $urandom_range(0, 4);
        period = 24'(p);
        stop_on_stable = 1'($urandom_range(0, 1));
        exp_space = ((p == 0) ? 1 : p) + 5;
        have_last = 0;
        chk_space = 1;
        base = n_steps + $urandom_range(1, 6);
        run = 1;
        wait_steps(base, 120, "rnd_steps");
        run = 0;
        chk_space = 0;
        wait_idle(30, "rnd_idle");
      end
    end

    repeat (5) @(negedge clk);
    check("wq_empty", 64'(wq.size()), 64'h0);
    check("sq_empty", 64'(sq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
